// File: rtl/bubbledrive8_flashbus_arb.sv
// Two-master arbiter for the shared W25Q32 SPI flash bus (emulator core vs USB/MPSSE).
// All flash pins are registered, so an ownership change can never glitch nROMCS.
module bubbledrive8_flashbus_arb #(
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter bit PRIO_EMU       = 1'b1
) (
  input  logic MCLK,
  input  logic nRESET,
  input  logic nREQ_EMU,
  output logic nGNT_EMU,
  input  logic nCS_EMU,
  input  logic MOSI_EMU,
  input  logic CLK_EMU,
  output logic MISO_EMU,
  input  logic nREQ_USB,
  output logic nGNT_USB,
  input  logic nCS_USB,
  input  logic MOSI_USB,
  input  logic CLK_USB,
  output logic MISO_USB,
  output logic nROMCS,
  output logic ROMMOSI,
  output logic ROMCLK,
  input  logic ROMMISO,
  output logic nBUSY,
  output logic TIMEOUT
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GW-1:0] GUARD_LAST   = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT_EMU,
    S_GRANT_USB,
    S_GUARD
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [GW-1:0]   guard_cnt_q, guard_cnt_d;
  logic            last_usb_q, last_usb_d;
  logic            mask_emu_q, mask_emu_d;
  logic            mask_usb_q, mask_usb_d;
  logic            ngnt_emu_q, ngnt_emu_d;
  logic            ngnt_usb_q, ngnt_usb_d;
  logic            nromcs_q, nromcs_d;
  logic            rommosi_q, rommosi_d;
  logic            romclk_q, romclk_d;
  logic            nbusy_q, nbusy_d;
  logic            timeout_q, timeout_d;

  logic owner_usb, own_nreq, own_ncs, own_mosi, own_clk;
  logic req_emu, req_usb, timeout_hit;

  always_comb begin
    owner_usb = (state_q == S_GRANT_USB);
    own_nreq  = owner_usb ? nREQ_USB : nREQ_EMU;
    own_ncs   = owner_usb ? nCS_USB  : nCS_EMU;
    own_mosi  = owner_usb ? MOSI_USB : MOSI_EMU;
    own_clk   = owner_usb ? CLK_USB  : CLK_EMU;
    // A master revoked by timeout stays ineligible until its request is seen high.
    req_emu   = ~nREQ_EMU & ~mask_emu_q;
    req_usb   = ~nREQ_USB & ~mask_usb_q;
    timeout_hit = (TIMEOUT_CYCLES != 0) && own_ncs && (idle_cnt_q == TIMEOUT_LAST);

    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    guard_cnt_d = guard_cnt_q;
    last_usb_d  = last_usb_q;
    mask_emu_d  = mask_emu_q & ~nREQ_EMU;
    mask_usb_d  = mask_usb_q & ~nREQ_USB;
    nromcs_d    = 1'b1;
    rommosi_d   = 1'b0;
    romclk_d    = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_emu && (!req_usb || PRIO_EMU || last_usb_q)) begin
          state_d    = S_GRANT_EMU;
          last_usb_d = 1'b0;
          idle_cnt_d = '0;
        end else if (req_usb) begin
          state_d    = S_GRANT_USB;
          last_usb_d = 1'b1;
          idle_cnt_d = '0;
        end
      end
      S_GRANT_EMU, S_GRANT_USB: begin
        if (own_nreq) begin
          state_d     = S_GUARD;
          guard_cnt_d = '0;
        end else if (timeout_hit) begin
          state_d     = S_GUARD;
          guard_cnt_d = '0;
          timeout_d   = 1'b1;
          if (owner_usb) mask_usb_d = 1'b1;
          else           mask_emu_d = 1'b1;
        end else begin
          nromcs_d   = own_ncs;
          rommosi_d  = own_mosi;
          romclk_d   = own_clk;
          idle_cnt_d = !own_ncs ? '0 :
                       (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
        end
      end
      S_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) state_d = S_IDLE;
        else                           guard_cnt_d = guard_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    ngnt_emu_d = (state_d != S_GRANT_EMU);
    ngnt_usb_d = (state_d != S_GRANT_USB);
    nbusy_d    = (state_d == S_IDLE);
  end

  always_ff @(posedge MCLK) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      idle_cnt_q  <= '0;
      guard_cnt_q <= '0;
      last_usb_q  <= 1'b0;
      mask_emu_q  <= 1'b0;
      mask_usb_q  <= 1'b0;
      ngnt_emu_q  <= 1'b1;
      ngnt_usb_q  <= 1'b1;
      nromcs_q    <= 1'b1;
      rommosi_q   <= 1'b0;
      romclk_q    <= 1'b0;
      nbusy_q     <= 1'b1;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      last_usb_q  <= last_usb_d;
      mask_emu_q  <= mask_emu_d;
      mask_usb_q  <= mask_usb_d;
      ngnt_emu_q  <= ngnt_emu_d;
      ngnt_usb_q  <= ngnt_usb_d;
      nromcs_q    <= nromcs_d;
      rommosi_q   <= rommosi_d;
      romclk_q    <= romclk_d;
      nbusy_q     <= nbusy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign nGNT_EMU = ngnt_emu_q;
  assign nGNT_USB = ngnt_usb_q;
  assign nROMCS   = nromcs_q;
  assign ROMMOSI  = rommosi_q;
  assign ROMCLK   = romclk_q;
  assign nBUSY    = nbusy_q;
  assign TIMEOUT  = timeout_q;
  // Read data is passed straight through so the owner samples it in the same MCLK.
  assign MISO_EMU = (state_q == S_GRANT_EMU) ? ROMMISO : 1'b1;
  assign MISO_USB = (state_q == S_GRANT_USB) ? ROMMISO : 1'b1;

endmodule

// File: tb/tb_bubbledrive8_flashbus_arb.sv
// Scoreboard bench for the flash bus arbiter: instance a has fixed EMU priority,
// instance b round-robin; both see the same master stimulus.
module tb_bubbledrive8_flashbus_arb;

  localparam int S_GE = 0, S_GU = 1, S_CS = 2, S_CLK = 3, S_MOSI = 4, S_BUSY = 5,
                 S_TO = 6, S_ME = 7, S_MU = 8, S_GEB = 9, S_GUB = 10;

  typedef struct {
    int    cyc;
    string tag;
    int    sel;
    logic  val;
  } exp_t;

  logic MCLK = 1'b0;
  logic nRESET = 1'b0;
  logic nreq_emu = 1'b1, ncs_emu = 1'b1, mosi_emu = 1'b0, clk_emu = 1'b0;
  logic nreq_usb = 1'b1, ncs_usb = 1'b1, mosi_usb = 1'b0, clk_usb = 1'b0;
  logic miso_bit = 1'b1;
  logic ROMMISO;

  logic nGNT_EMU_a, nGNT_USB_a, MISO_EMU_a, MISO_USB_a, nROMCS_a, ROMMOSI_a, ROMCLK_a, nBUSY_a, TIMEOUT_a;
  logic nGNT_EMU_b, nGNT_USB_b, MISO_EMU_b, MISO_USB_b, nROMCS_b, ROMMOSI_b, ROMCLK_b, nBUSY_b, TIMEOUT_b;

  exp_t        sb[$];
  int          cyc = 0;
  int          check_count = 0;
  int          pass_count = 0;
  int          b;
  logic [7:0]  cmd;
  logic [23:0] jedec;
  logic [23:0] rx;

  // The flash only drives its data line while it is selected.
  assign ROMMISO = nROMCS_a ? 1'b1 : miso_bit;

  bubbledrive8_flashbus_arb #(.GUARD_CYCLES(4), .TIMEOUT_CYCLES(100), .PRIO_EMU(1'b1)) dut_a (
    .MCLK(MCLK), .nRESET(nRESET),
    .nREQ_EMU(nreq_emu), .nGNT_EMU(nGNT_EMU_a), .nCS_EMU(ncs_emu), .MOSI_EMU(mosi_emu),
    .CLK_EMU(clk_emu), .MISO_EMU(MISO_EMU_a),
    .nREQ_USB(nreq_usb), .nGNT_USB(nGNT_USB_a), .nCS_USB(ncs_usb), .MOSI_USB(mosi_usb),
    .CLK_USB(clk_usb), .MISO_USB(MISO_USB_a),
    .nROMCS(nROMCS_a), .ROMMOSI(ROMMOSI_a), .ROMCLK(ROMCLK_a), .ROMMISO(ROMMISO),
    .nBUSY(nBUSY_a), .TIMEOUT(TIMEOUT_a)
  );

  bubbledrive8_flashbus_arb #(.GUARD_CYCLES(4), .TIMEOUT_CYCLES(100), .PRIO_EMU(1'b0)) dut_b (
    .MCLK(MCLK), .nRESET(nRESET),
    .nREQ_EMU(nreq_emu), .nGNT_EMU(nGNT_EMU_b), .nCS_EMU(ncs_emu), .MOSI_EMU(mosi_emu),
    .CLK_EMU(clk_emu), .MISO_EMU(MISO_EMU_b),
    .nREQ_USB(nreq_usb), .nGNT_USB(nGNT_USB_b), .nCS_USB(ncs_usb), .MOSI_USB(mosi_usb),
    .CLK_USB(clk_usb), .MISO_USB(MISO_USB_b),
    .nROMCS(nROMCS_b), .ROMMOSI(ROMMOSI_b), .ROMCLK(ROMCLK_b), .ROMMISO(ROMMISO),
    .nBUSY(nBUSY_b), .TIMEOUT(TIMEOUT_b)
  );

  always #5 MCLK = ~MCLK;

  always @(posedge MCLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic getObs(input int sel);
    case (sel)
      S_GE:    return nGNT_EMU_a;
      S_GU:    return nGNT_USB_a;
      S_CS:    return nROMCS_a;
      S_CLK:   return ROMCLK_a;
      S_MOSI:  return ROMMOSI_a;
      S_BUSY:  return nBUSY_a;
      S_TO:    return TIMEOUT_a;
      S_ME:    return MISO_EMU_a;
      S_MU:    return MISO_USB_a;
      S_GEB:   return nGNT_EMU_b;
      S_GUB:   return nGNT_USB_b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic expectAt(input int c, input string tag, input int sel, input logic v);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  // Expected values are compared mid-cycle, away from the sampling edge.
  always @(negedge MCLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput(e.tag, {31'b0, getObs(e.sel)}, {31'b0, e.val});
    end
  end

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] emu, input logic [3:0] usb);
    {nreq_emu, ncs_emu, mosi_emu, clk_emu} = emu;
    {nreq_usb, ncs_usb, mosi_usb, clk_usb} = usb;
  endtask

  task automatic resetDut();
    int c;
    applyStimulus(4'b1100, 4'b1100);
    miso_bit = 1'b1;
    nRESET = 1'b0;
    c = cyc;
    at(c + 2);
    expectAt(c + 2, "rst_gnt_emu", S_GE, 1'b1);
    expectAt(c + 2, "rst_gnt_usb", S_GU, 1'b1);
    expectAt(c + 2, "rst_romcs", S_CS, 1'b1);
    expectAt(c + 2, "rst_romclk", S_CLK, 1'b0);
    expectAt(c + 2, "rst_rommosi", S_MOSI, 1'b0);
    expectAt(c + 2, "rst_busy", S_BUSY, 1'b1);
    expectAt(c + 2, "rst_timeout", S_TO, 1'b0);
    expectAt(c + 2, "rst_miso_emu", S_ME, 1'b1);
    expectAt(c + 2, "rst_miso_usb", S_MU, 1'b1);
    expectAt(c + 2, "rst_gnt_emu_b", S_GEB, 1'b1);
    expectAt(c + 2, "rst_gnt_usb_b", S_GUB, 1'b1);
    at(c + 3);
    nRESET = 1'b1;
    at(c + 4);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cmd   = 8'h9F;
    jedec = 24'hEF4016;
    rx    = '0;

    // Single EMU ownership: grant latency, pin latency, release and guard.
    resetDut();
    b = cyc;
    expectAt(b + 10, "t1_pre_gnt", S_GE, 1'b1);
    expectAt(b + 11, "t1_gnt", S_GE, 1'b0);
    expectAt(b + 11, "t1_busy", S_BUSY, 1'b0);
    expectAt(b + 11, "t1_cs_idle", S_CS, 1'b1);
    expectAt(b + 13, "t1_cs", S_CS, 1'b0);
    expectAt(b + 13, "t1_clk", S_CLK, 1'b1);
    expectAt(b + 13, "t1_mosi", S_MOSI, 1'b1);
    expectAt(b + 13, "t1_miso_emu", S_ME, 1'b0);
    expectAt(b + 13, "t1_miso_usb", S_MU, 1'b1);
    expectAt(b + 15, "t1_cs_hi", S_CS, 1'b1);
    expectAt(b + 50, "t1_held", S_GE, 1'b0);
    expectAt(b + 51, "t1_rel_gnt", S_GE, 1'b1);
    expectAt(b + 51, "t1_rel_cs", S_CS, 1'b1);
    expectAt(b + 54, "t1_guard_busy", S_BUSY, 1'b0);
    expectAt(b + 55, "t1_idle_busy", S_BUSY, 1'b1);
    at(b + 10); nreq_emu = 1'b0;
    at(b + 12); ncs_emu = 1'b0; clk_emu = 1'b1; mosi_emu = 1'b1; miso_bit = 1'b0;
    at(b + 14); ncs_emu = 1'b1; clk_emu = 1'b0; mosi_emu = 1'b0; miso_bit = 1'b1;
    at(b + 50); nreq_emu = 1'b1;
    at(b + 58);

    // Simultaneous requests with fixed priority: EMU first, USB after guard.
    resetDut();
    b = cyc;
    expectAt(b + 6, "t2_gnt_emu", S_GE, 1'b0);
    expectAt(b + 6, "t2_usb_wait", S_GU, 1'b1);
    expectAt(b + 8, "t2_cs", S_CS, 1'b0);
    expectAt(b + 8, "t2_miso_emu", S_ME, 1'b0);
    expectAt(b + 8, "t2_miso_usb", S_MU, 1'b1);
    expectAt(b + 8, "t2_usb_wait2", S_GU, 1'b1);
    expectAt(b + 21, "t2_emu_rel", S_GE, 1'b1);
    expectAt(b + 21, "t2_usb_guard", S_GU, 1'b1);
    expectAt(b + 25, "t2_usb_pre", S_GU, 1'b1);
    expectAt(b + 26, "t2_gnt_usb", S_GU, 1'b0);
    expectAt(b + 26, "t2_emu_off", S_GE, 1'b1);
    expectAt(b + 31, "t2_usb_rel", S_GU, 1'b1);
    at(b + 5);  nreq_emu = 1'b0; nreq_usb = 1'b0;
    at(b + 7);  ncs_emu = 1'b0; miso_bit = 1'b0;
    at(b + 9);  ncs_emu = 1'b1; miso_bit = 1'b1;
    at(b + 20); nreq_emu = 1'b1;
    at(b + 30); nreq_usb = 1'b1;
    at(b + 37);

    // Round-robin on instance b: USB, EMU, USB, EMU with 20-cycle ownerships.
    resetDut();
    b = cyc;
    for (int k = 0; k < 4; k++) begin
      int g;
      g = b + 3 + 25 * k;
      expectAt(g - 1, "t3_pre_gnt", (k % 2 == 0) ? S_GUB : S_GEB, 1'b1);
      expectAt(g, "t3_gnt", (k % 2 == 0) ? S_GUB : S_GEB, 1'b0);
      expectAt(g, "t3_other", (k % 2 == 0) ? S_GEB : S_GUB, 1'b1);
      expectAt(g + 20, "t3_rel", (k % 2 == 0) ? S_GUB : S_GEB, 1'b1);
    end
    at(b + 2); nreq_emu = 1'b0; nreq_usb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int g;
      g = b + 3 + 25 * k;
      at(g + 19);
      if (k % 2 == 0) nreq_usb = 1'b1; else nreq_emu = 1'b1;
      at(g + 20);
      if (k < 3) begin
        if (k % 2 == 0) nreq_usb = 1'b0; else nreq_emu = 1'b0;
      end else begin
        nreq_usb = 1'b1;
      end
    end
    at(b + 110);

    // Timeout revoke of an idle USB owner, then masking until the request toggles.
    resetDut();
    b = cyc;
    expectAt(b + 3, "t4_gnt", S_GU, 1'b0);
    expectAt(b + 102, "t4_still_gnt", S_GU, 1'b0);
    expectAt(b + 102, "t4_no_to", S_TO, 1'b0);
    expectAt(b + 103, "t4_revoke", S_GU, 1'b1);
    expectAt(b + 103, "t4_to_pulse", S_TO, 1'b1);
    expectAt(b + 103, "t4_cs", S_CS, 1'b1);
    expectAt(b + 104, "t4_to_end", S_TO, 1'b0);
    expectAt(b + 110, "t4_masked", S_GU, 1'b1);
    expectAt(b + 110, "t4_idle", S_BUSY, 1'b1);
    expectAt(b + 114, "t4_pre_regnt", S_GU, 1'b1);
    expectAt(b + 115, "t4_regnt", S_GU, 1'b0);
    expectAt(b + 121, "t4_rel", S_GU, 1'b1);
    at(b + 2);   nreq_usb = 1'b0;
    at(b + 112); nreq_usb = 1'b1;
    at(b + 114); nreq_usb = 1'b0;
    at(b + 120); nreq_usb = 1'b1;
    at(b + 127);

    // Reset in the middle of an EMU read: immediate deselect, no guard.
    resetDut();
    b = cyc;
    expectAt(b + 3, "t5_gnt", S_GE, 1'b0);
    expectAt(b + 6, "t5_cs", S_CS, 1'b0);
    expectAt(b + 7, "t5_cs2", S_CS, 1'b0);
    expectAt(b + 7, "t5_clk", S_CLK, 1'b1);
    expectAt(b + 8, "t5_rst_cs", S_CS, 1'b1);
    expectAt(b + 8, "t5_rst_clk", S_CLK, 1'b0);
    expectAt(b + 8, "t5_rst_gnt_emu", S_GE, 1'b1);
    expectAt(b + 8, "t5_rst_gnt_usb", S_GU, 1'b1);
    expectAt(b + 8, "t5_rst_busy", S_BUSY, 1'b1);
    expectAt(b + 10, "t5_after_cs", S_CS, 1'b1);
    expectAt(b + 10, "t5_after_clk", S_CLK, 1'b0);
    expectAt(b + 10, "t5_after_gnt", S_GE, 1'b1);
    expectAt(b + 10, "t5_after_busy", S_BUSY, 1'b1);
    at(b + 2);  nreq_emu = 1'b0;
    at(b + 4);  ncs_emu = 1'b0;
    at(b + 6);  clk_emu = 1'b1; mosi_emu = 1'b1;
    at(b + 7);  nRESET = 1'b0;
    at(b + 8);  nRESET = 1'b1; nreq_emu = 1'b1;
    at(b + 11); ncs_emu = 1'b1; clk_emu = 1'b0; mosi_emu = 1'b0;
    at(b + 13);

    // EMU reads the JEDEC ID while USB illegally holds its nCS low.
    resetDut();
    b = cyc;
    for (int i = 0; i < 32; i++) begin
      int c;
      c = b + 4 + 2 * i;
      expectAt(c + 1, "t6_cs", S_CS, 1'b0);
      if (i < 8) expectAt(c + 1, "t6_mosi", S_MOSI, cmd[7 - i]);
      else       expectAt(c + 1, "t6_miso_usb", S_MU, 1'b1);
      expectAt(c + 1, "t6_clk_lo", S_CLK, 1'b0);
      expectAt(c + 2, "t6_clk_hi", S_CLK, 1'b1);
    end
    expectAt(b + 69, "t6_cs_end", S_CS, 1'b1);
    at(b + 1); ncs_usb = 1'b0; clk_usb = 1'b1; mosi_usb = 1'b1;
    at(b + 2); nreq_emu = 1'b0;
    for (int i = 0; i < 32; i++) begin
      int c;
      c = b + 4 + 2 * i;
      at(c);
      ncs_emu  = 1'b0;
      clk_emu  = 1'b0;
      mosi_emu = (i < 8) ? cmd[7 - i] : 1'b0;
      at(c + 1);
      clk_emu = 1'b1;
      if (i >= 8) begin
        miso_bit = jedec[23 - (i - 8)];
        #1;
        rx = {rx[22:0], MISO_EMU_a};
      end
    end
    at(b + 68); ncs_emu = 1'b1; clk_emu = 1'b0; mosi_emu = 1'b0; miso_bit = 1'b1;
    checkOutput("t6_jedec", {8'b0, rx}, {8'b0, jedec});
    at(b + 70); nreq_emu = 1'b1; ncs_usb = 1'b1; clk_usb = 1'b0; mosi_usb = 1'b0;
    at(b + 77);

    checkOutput("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
